// File: rtl/fir_sample_sequencer_if.sv
// Sample-in / result-out valid-ready streams around the FIR sequencer.
// The upstream producer and downstream consumer share one bundle; the sequencer is the slave side.
interface fir_sample_sequencer_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fir_sample_sequencer.sv
// Feeds buffered samples one at a time into the 19-tap FIR and returns each rounded result
// downstream; the filter is only strobed once its previous pass has been fully drained.
module fir_sample_sequencer #(
  parameter int DATA_W         = 16,
  parameter int FIFO_DEPTH     = 4,
  parameter int COMPUTE_CYCLES = 12
) (
  input  logic              clock,
  input  logic              reset,
  fir_sample_sequencer_if.slave bus,
  output logic              fir_start,
  output logic [DATA_W-1:0] fir_sample,
  input  logic [DATA_W-1:0] fir_result,
  output logic              busy,
  output logic [15:0]       sample_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 1;
  localparam int CW = $clog2(COMPUTE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, HOLD} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [OW-1:0]     occ;
  logic              full, empty, push, pop;
  logic [DATA_W-1:0] head;

  assign full  = (occ == OW'(FIFO_DEPTH));
  assign empty = (occ == '0);
  // Ready ignores a same-cycle pop, so a full FIFO can never be written.
  assign bus.in_ready = !full && !reset;
  assign push  = bus.in_valid && bus.in_ready;
  assign pop   = (state == IDLE) && !empty;
  assign head  = mem[rd_ptr];

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy          = (state != IDLE);

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // The filter's own done flag is ignored; the pass is timed locally by cnt.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      fir_start    <= 1'b0;
      fir_sample   <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      sample_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            fir_sample <= head;
            fir_start  <= 1'b1;
            state      <= LOAD;
          end
        end
        LOAD: begin
          fir_start <= 1'b0;
          cnt       <= '0;
          state     <= COMPUTE;
        end
        COMPUTE: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(COMPUTE_CYCLES - 1)) begin
            out_data_q  <= fir_result;
            out_valid_q <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q  <= 1'b0;
            sample_count <= sample_count + 16'd1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Directed bench for fir_sample_sequencer: reset, single pass, burst, back-pressure,
// mid-compute reset and result-counter wrap.
module tb_fir_sample_sequencer;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          fir_start;
  logic [DW-1:0] fir_sample;
  logic [DW-1:0] fir_result;
  logic          busy;
  logic [15:0]   sample_count;

  fir_sample_sequencer_if #(.DATA_W(DW)) bus();

  fir_sample_sequencer #(.DATA_W(DW), .FIFO_DEPTH(4), .COMPUTE_CYCLES(12)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .fir_start    (fir_start),
    .fir_sample   (fir_sample),
    .fir_result   (fir_result),
    .busy         (busy),
    .sample_count (sample_count)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int dbl_start = 0;
  logic prev_start = 1'b0;
  int          st_cyc [$];
  logic [15:0] st_smp [$];

  always @(posedge clock) cyc <= cyc + 1;

  // Log every start strobe with its cycle and sample.
  always @(negedge clock) begin
    if (fir_start) begin
      st_cyc.push_back(cyc);
      st_smp.push_back(fir_sample);
      if (prev_start) dbl_start <= dbl_start + 1;
    end
    prev_start <= fir_start;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push(input string tag, input logic [15:0] v);
    int t = 0;
    while (!bus.in_ready && t < 200) begin step(1); t++; end
    if (t >= 200) chk(tag, bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    step(1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int t = 0;
    while (!bus.out_valid && t < 200) begin step(1); t++; end
    chk(tag, bus.out_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int base, bad, t;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    fir_result    = 16'h1234;

    // reset held for two edges
    reset = 1'b1;
    step(2);
    chk("rst_start",   fir_start, 0);
    chk("rst_sample",  fir_sample, 0);
    chk("rst_ovalid",  bus.out_valid, 0);
    chk("rst_odata",   bus.out_data, 0);
    chk("rst_count",   sample_count, 0);
    chk("rst_busy",    busy, 0);
    chk("rst_inready", bus.in_ready, 0);
    reset = 1'b0;
    step(1);
    chk("rel_inready", bus.in_ready, 1);
    chk("rst_nostart", st_cyc.size(), 0);

    // single sample: start after E1, result after E14
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0100;
    step(1);
    bus.in_valid = 1'b0;
    chk("e0_start", fir_start, 0);
    step(1);
    chk("e1_start",  fir_start, 1);
    chk("e1_sample", fir_sample, 16'h0100);
    chk("e1_busy",   busy, 1);
    step(1);
    chk("e2_start", fir_start, 0);
    step(11);
    chk("e13_ovalid", bus.out_valid, 0);
    step(1);
    chk("e14_ovalid", bus.out_valid, 1);
    chk("e14_odata",  bus.out_data, 16'h1234);
    step(1);
    chk("e15_ovalid", bus.out_valid, 0);
    chk("e15_count",  sample_count, 1);
    chk("e15_busy",   busy, 0);
    chk("single_one_start", st_cyc.size(), 1);

    // burst of six: FIFO fills after the fifth push
    base = st_cyc.size();
    for (int k = 1; k <= 6; k++) begin
      t = 0;
      while (!bus.in_ready && t < 200) begin step(1); t++; end
      if (t >= 200) chk("burst_wait", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(k);
      step(1);
      bus.in_valid = 1'b0;
      if (k == 5) chk("burst_full", bus.in_ready, 0);
    end
    t = 0;
    while (sample_count != 16'd7 && t < 300) begin step(1); t++; end
    chk("burst_count", sample_count, 7);
    chk("burst_pulses", st_cyc.size(), base + 6);
    if (st_cyc.size() == base + 6) begin
      for (int i = 0; i < 6; i++) chk($sformatf("burst_smp%0d", i), st_smp[base+i], i + 1);
      for (int i = 1; i < 6; i++) chk($sformatf("burst_gap%0d", i), st_cyc[base+i] - st_cyc[base+i-1], 15);
    end

    // back-pressure: result held 30 cycles, queued sample waits
    bus.out_ready = 1'b0;
    fir_result    = 16'h5A5A;
    push("bp_push1", 16'h00AA);
    wait_out("bp_ovalid");
    push("bp_push2", 16'h00BB);
    fir_result = 16'h0000;
    base = st_cyc.size();
    bad = 0;
    repeat (30) begin
      step(1);
      if (!bus.out_valid || bus.out_data != 16'h5A5A) bad++;
    end
    chk("bp_stable",  bad, 0);
    chk("bp_nostart", st_cyc.size(), base);
    bus.out_ready = 1'b1;
    step(1);
    chk("bp_hs_ovalid", bus.out_valid, 0);
    chk("bp_hs_start",  fir_start, 0);
    chk("bp_hs_count",  sample_count, 8);
    step(1);
    chk("bp_next_start",  fir_start, 1);
    chk("bp_next_sample", fir_sample, 16'h00BB);
    wait_out("bp2_ovalid");
    chk("bp2_data", bus.out_data, 16'h0000);
    step(1);
    chk("bp2_count", sample_count, 9);

    // reset during COMPUTE at cnt 5 with two queued samples
    fir_result   = 16'h7777;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0011; step(1);
    bus.in_data  = 16'h0022; step(1);
    bus.in_data  = 16'h0033; step(1);
    bus.in_valid = 1'b0;
    step(5);
    chk("mr_busy_pre", busy, 1);
    reset = 1'b1;
    step(1);
    chk("mr_ovalid",  bus.out_valid, 0);
    chk("mr_busy",    busy, 0);
    chk("mr_start",   fir_start, 0);
    chk("mr_inready", bus.in_ready, 0);
    chk("mr_count",   sample_count, 0);
    reset = 1'b0;
    base = st_cyc.size();
    bad = 0;
    repeat (10) begin
      step(1);
      if (bus.out_valid) bad++;
    end
    chk("mr_no_out",   bad, 0);
    chk("mr_no_start", st_cyc.size(), base);
    chk("mr_idle",     busy, 0);
    push("mr_push", 16'h0044);
    step(1);
    chk("mr_new_start",  fir_start, 1);
    chk("mr_new_sample", fir_sample, 16'h0044);
    wait_out("mr_ovalid2");
    chk("mr_data", bus.out_data, 16'h7777);
    step(1);
    chk("mr_count2", sample_count, 1);

    // result counter wrap
    force dut.sample_count = 16'hFFFE;
    step(1);
    release dut.sample_count;
    step(1);
    chk("wrap_pre", sample_count, 16'hFFFE);
    push("wrap_push1", 16'h0001);
    wait_out("wrap_ov1");
    step(1);
    chk("wrap_ffff", sample_count, 16'hFFFF);
    push("wrap_push2", 16'h0002);
    wait_out("wrap_ov2");
    step(1);
    chk("wrap_zero", sample_count, 16'h0000);

    chk("start_single_cycle", dbl_start, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
